y_writer: RTL and testbench

Downstream sink of the row kernel. Accepts the kernel's packed 256-bit result beats, which carry four 64-bit Y words each. Buffers them in an internal FIFO and writes them to the Y vector region in memory over an AXI4 write master, using INCR bursts of up to `MAX_BURST` beats. One job is one contiguous write of `Write_Length` beats starting at `YVal_BASE_ADDR`; completion is reported by a one-cycle `Write_Done` pulse.

---
 rtl/y_writer.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_y_writer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/y_writer.sv
// y_writer: buffers packed 256-bit Y beats from the row kernel in a FIFO and writes
// them to the Y region over an AXI4 write master, one INCR burst outstanding at a time.
module y_writer #(
    parameter logic [31:0] YVal_BASE_ADDR = 32'h4000_0000,
    parameter int unsigned MAX_BURST      = 16,
    parameter int unsigned FIFO_DEPTH     = 32
) (
    input  logic         clk,
    input  logic         rstn,

    input  logic         Write_Begin,
    input  logic [31:0]  Write_Length,
    output logic         Write_Done,
    output logic         Write_Error,

    input  logic         input_valid,
    output logic         input_ready,
    input  logic [255:0] input_data,

    output logic         m_axi_Y_awid,
    output logic [47:0]  m_axi_Y_awaddr,
    output logic [7:0]   m_axi_Y_awlen,
    output logic [2:0]   m_axi_Y_awsize,
    output logic [1:0]   m_axi_Y_awburst,
    output logic         m_axi_Y_awlock,
    output logic [3:0]   m_axi_Y_awcache,
    output logic [2:0]   m_axi_Y_awprot,
    output logic [3:0]   m_axi_Y_awqos,
    output logic         m_axi_Y_awvalid,
    input  logic         m_axi_Y_awready,

    output logic [255:0] m_axi_Y_wdata,
    output logic [31:0]  m_axi_Y_wstrb,
    output logic         m_axi_Y_wlast,
    output logic         m_axi_Y_wvalid,
    input  logic         m_axi_Y_wready,

    input  logic         m_axi_Y_bid,
    input  logic [1:0]   m_axi_Y_bresp,
    input  logic         m_axi_Y_bvalid,
    output logic         m_axi_Y_bready
);

    localparam int unsigned PW          = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] PTR_ONE     = {{PW{1'b0}}, 1'b1};
    localparam logic [7:0]  MAX_LEN     = 8'(MAX_BURST - 1);
    localparam logic [31:0] MAX_BURST_W = 32'(MAX_BURST);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_DATA = 3'd2,
        ST_RESP = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t         state_r;
    state_t         state_nx_s;

    logic [255:0]   mem_r [FIFO_DEPTH];
    logic [PW:0]    wr_ptr_r;
    logic [PW:0]    rd_ptr_r;
    logic           fifo_empty_s;
    logic           fifo_full_s;
    logic           push_s;
    logic           pop_s;
    logic [255:0]   head_s;

    logic [31:0]    remaining_r;
    logic [47:0]    addr_r;
    logic [7:0]     awlen_r;
    logic [7:0]     beat_cnt_r;
    logic           write_error_r;
    logic           awvalid_r;
    logic           bready_r;
    logic           write_done_r;

    logic           awvalid_nx_s;
    logic           bready_nx_s;
    logic           done_nx_s;
    logic [7:0]     awlen_nx_s;
    logic [31:0]    rem_src_s;
    logic [31:0]    burst_s;
    logic [31:0]    rem_after_s;
    logic           aw_hs_s;
    logic           wvalid_s;
    logic           wlast_s;
    logic           b_hs_s;
    logic           unused_bid_s;

    // FIFO status comes from registered pointers only; the extra MSB separates full from empty
    assign fifo_empty_s = (wr_ptr_r == rd_ptr_r);
    assign fifo_full_s  = (wr_ptr_r[PW] != rd_ptr_r[PW]) &&
                          (wr_ptr_r[PW-1:0] == rd_ptr_r[PW-1:0]);
    assign push_s       = input_valid & ~fifo_full_s;
    assign pop_s        = wvalid_s & m_axi_Y_wready;
    assign head_s       = mem_r[rd_ptr_r[PW-1:0]];

    assign aw_hs_s      = awvalid_r & m_axi_Y_awready;
    assign wvalid_s     = (state_r == ST_DATA) & ~fifo_empty_s;
    assign wlast_s      = (state_r == ST_DATA) & (beat_cnt_r == awlen_r);
    assign b_hs_s       = bready_r & m_axi_Y_bvalid;
    assign burst_s      = {24'd0, awlen_r} + 32'd1;
    assign rem_after_s  = remaining_r - burst_s;
    assign unused_bid_s = m_axi_Y_bid;

    // FIFO storage array
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r[PW-1:0]] <= input_data;
        end
    end

    // FIFO read/write pointers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_r <= {(PW+1){1'b0}};
            rd_ptr_r <= {(PW+1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // State register together with the registered handshake/status outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r      <= ST_IDLE;
            awvalid_r    <= 1'b0;
            bready_r     <= 1'b0;
            write_done_r <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            awvalid_r    <= awvalid_nx_s;
            bready_r     <= bready_nx_s;
            write_done_r <= done_nx_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (Write_Begin) begin
                    if (Write_Length == 32'd0) begin
                        state_nx_s = ST_DONE;
                    end else begin
                        state_nx_s = ST_ADDR;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (aw_hs_s) begin
                    state_nx_s = ST_DATA;
                end else begin
                    state_nx_s = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (pop_s && wlast_s) begin
                    state_nx_s = ST_RESP;
                end else begin
                    state_nx_s = ST_DATA;
                end
            end
            ST_RESP: begin
                if (b_hs_s) begin
                    if (rem_after_s == 32'd0) begin
                        state_nx_s = ST_DONE;
                    end else begin
                        state_nx_s = ST_ADDR;
                    end
                end else begin
                    state_nx_s = ST_RESP;
                end
            end
            ST_DONE: begin
                if (write_done_r) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_DONE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Next values of the registered outputs. A zero-length job enters DONE straight from
    // IDLE and raises the pulse one cycle later; after a final B it rises on DONE entry.
    always_comb begin
        awvalid_nx_s = (state_nx_s == ST_ADDR);
        bready_nx_s  = (state_nx_s == ST_RESP);
        if ((state_r == ST_RESP) && (state_nx_s == ST_DONE)) begin
            done_nx_s = 1'b1;
        end else if ((state_r == ST_DONE) && !write_done_r) begin
            done_nx_s = 1'b1;
        end else begin
            done_nx_s = 1'b0;
        end
    end

    // Length of the next burst: min(remaining, MAX_BURST) - 1
    always_comb begin
        if (state_r == ST_IDLE) begin
            rem_src_s = Write_Length;
        end else begin
            rem_src_s = rem_after_s;
        end
        if (rem_src_s >= MAX_BURST_W) begin
            awlen_nx_s = MAX_LEN;
        end else begin
            awlen_nx_s = rem_src_s[7:0] - 8'd1;
        end
    end

    // Job bookkeeping: remaining beats, burst address, sticky error
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            remaining_r   <= 32'd0;
            addr_r        <= 48'd0;
            write_error_r <= 1'b0;
        end else if ((state_r == ST_IDLE) && Write_Begin) begin
            remaining_r   <= Write_Length;
            addr_r        <= {16'd0, YVal_BASE_ADDR};
            write_error_r <= 1'b0;
        end else if ((state_r == ST_RESP) && b_hs_s) begin
            remaining_r   <= rem_after_s;
            addr_r        <= addr_r + {11'd0, burst_s, 5'd0};
            write_error_r <= write_error_r | (m_axi_Y_bresp != 2'b00);
        end
    end

    // Burst length is captured on ADDR entry so AW stays stable until accepted
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            awlen_r <= 8'd0;
        end else if ((state_nx_s == ST_ADDR) && (state_r != ST_ADDR)) begin
            awlen_r <= awlen_nx_s;
        end
    end

    // Beat counter within the current burst
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            beat_cnt_r <= 8'd0;
        end else if (aw_hs_s) begin
            beat_cnt_r <= 8'd0;
        end else if (pop_s) begin
            beat_cnt_r <= beat_cnt_r + 8'd1;
        end
    end

    assign input_ready     = ~fifo_full_s;
    assign Write_Done      = write_done_r;
    assign Write_Error     = write_error_r;

    assign m_axi_Y_awid    = 1'b0;
    assign m_axi_Y_awaddr  = addr_r;
    assign m_axi_Y_awlen   = awlen_r;
    assign m_axi_Y_awsize  = 3'b101;
    assign m_axi_Y_awburst = 2'b01;
    assign m_axi_Y_awlock  = 1'b0;
    assign m_axi_Y_awcache = 4'b0011;
    assign m_axi_Y_awprot  = 3'b000;
    assign m_axi_Y_awqos   = 4'b0000;
    assign m_axi_Y_awvalid = awvalid_r;

    assign m_axi_Y_wdata   = fifo_empty_s ? 256'd0 : head_s;
    assign m_axi_Y_wstrb   = {32{1'b1}};
    assign m_axi_Y_wlast   = wlast_s;
    assign m_axi_Y_wvalid  = wvalid_s;
    assign m_axi_Y_bready  = bready_r;

endmodule

// File: tb/tb_y_writer.sv
// Testbench for y_writer: directed jobs against an AXI slave model, with a
// queue-based reference of FIFO contents and expected bursts checked every cycle.
module tb_y_writer;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         Write_Begin = 1'b0;
    logic [31:0]  Write_Length = 32'd0;
    logic         Write_Done, Write_Error;
    logic         input_valid = 1'b0;
    logic         input_ready;
    logic [255:0] input_data = 256'd0;
    logic         awid, awlock, awvalid, wlast, wvalid, bready;
    logic [47:0]  awaddr;
    logic [7:0]   awlen;
    logic [2:0]   awsize, awprot;
    logic [1:0]   awburst;
    logic [3:0]   awcache, awqos;
    logic [255:0] wdata;
    logic [31:0]  wstrb;
    logic         awready = 1'b0;
    logic         wready = 1'b0;
    logic         bvalid = 1'b0;
    logic [1:0]   bresp = 2'b00;

    always #5 clk = ~clk;

    y_writer dut (
        .clk(clk), .rstn(rstn),
        .Write_Begin(Write_Begin), .Write_Length(Write_Length),
        .Write_Done(Write_Done), .Write_Error(Write_Error),
        .input_valid(input_valid), .input_ready(input_ready), .input_data(input_data),
        .m_axi_Y_awid(awid), .m_axi_Y_awaddr(awaddr), .m_axi_Y_awlen(awlen),
        .m_axi_Y_awsize(awsize), .m_axi_Y_awburst(awburst), .m_axi_Y_awlock(awlock),
        .m_axi_Y_awcache(awcache), .m_axi_Y_awprot(awprot), .m_axi_Y_awqos(awqos),
        .m_axi_Y_awvalid(awvalid), .m_axi_Y_awready(awready),
        .m_axi_Y_wdata(wdata), .m_axi_Y_wstrb(wstrb), .m_axi_Y_wlast(wlast),
        .m_axi_Y_wvalid(wvalid), .m_axi_Y_wready(wready),
        .m_axi_Y_bid(1'b0), .m_axi_Y_bresp(bresp), .m_axi_Y_bvalid(bvalid),
        .m_axi_Y_bready(bready)
    );

    int n_checks = 0;
    int n_errors = 0;

    // reference state
    logic [255:0] data_q[$];
    logic [55:0]  exp_aw_q[$];
    logic [55:0]  obs_aw_q[$];
    int  b_owed = 0, b_idx = 0, err_at = -1;
    int  cur_len = 0, beat = 0, beats_left = 0, done_cnt = 0;
    bit  in_burst = 0, job_active = 0, exp_err = 0;
    bit  prev_aw_stall = 0, prev_w_stall = 0;
    logic [55:0]  prev_aw;
    logic [256:0] prev_w;
    bit  push_seen = 0, feed_stall = 0, slv_stall = 0;
    int  src_idx = 0, src_total = 0;

    function automatic logic [255:0] pat(input int i);
        logic [31:0] u;
        u = i;
        return {4{{32'hC0DE0000 + u, u ^ 32'h5A5A5A5A}}};
    endfunction

    task automatic chk(input string nm, input logic [263:0] act, input logic [263:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // compare process: every cycle, on the falling edge
    initial forever begin
        bit rdy_exp;
        @(negedge clk);
        if (rstn) begin
            rdy_exp = (data_q.size() < 32);
            chk("input_ready", input_ready, rdy_exp);
            chk("awvalid", awvalid, job_active && !in_burst && b_owed == 0 && exp_aw_q.size() > 0);
            chk("wvalid", wvalid, in_burst && data_q.size() > 0);
            chk("bready", bready, b_owed > 0);
            chk("Write_Error", Write_Error, exp_err);
            if (prev_aw_stall) chk("aw_stable", {awvalid, awaddr, awlen}, {1'b1, prev_aw});
            if (prev_w_stall)  chk("w_stable", {wvalid, wlast, wdata}, {1'b1, prev_w});
            prev_aw_stall = awvalid && !awready;
            prev_aw       = {awaddr, awlen};
            prev_w_stall  = wvalid && !wready;
            prev_w        = {wlast, wdata};
            if (awvalid && awready && exp_aw_q.size() > 0) begin
                chk("aw_fields", {awaddr, awlen}, exp_aw_q[0]);
                obs_aw_q.push_back({awaddr, awlen});
                cur_len = int'(exp_aw_q[0][7:0]);
                void'(exp_aw_q.pop_front());
                in_burst = 1;
                beat = 0;
            end
            if (wvalid && wready && in_burst && data_q.size() > 0) begin
                chk("wdata", wdata, data_q[0]);
                chk("wlast", wlast, beat == cur_len);
                void'(data_q.pop_front());
                beats_left--;
                if (beat == cur_len) begin
                    in_burst = 0;
                    b_owed++;
                end else begin
                    beat++;
                end
            end
            if (bvalid && bready && b_owed > 0) begin
                b_owed--;
                b_idx++;
                if (bresp != 2'b00) exp_err = 1;
            end
            push_seen = input_valid && rdy_exp;
            if (push_seen) data_q.push_back(input_data);
            if (Write_Begin && !job_active) begin
                job_active = 1;
                exp_err    = 0;
                beats_left = int'(Write_Length);
                b_idx      = 0;
            end
            if (Write_Done) begin
                chk("done_legal", {job_active, beats_left == 0, b_owed == 0, exp_aw_q.size() == 0}, 4'b1111);
                job_active = 0;
                done_cnt++;
            end
        end else begin
            prev_aw_stall = 0;
            prev_w_stall  = 0;
            push_seen     = 0;
        end
    end

    // AXI slave
    initial forever begin
        @(posedge clk); #1;
        awready = slv_stall ? ($urandom_range(0, 1) == 1) : 1'b1;
        wready  = slv_stall ? ($urandom_range(0, 1) == 1) : 1'b1;
        bvalid  = (b_owed > 0) && (slv_stall ? ($urandom_range(0, 1) == 1) : 1'b1);
        bresp   = (bvalid && b_idx == err_at) ? 2'b10 : 2'b00;
    end

    // kernel-side feeder
    initial forever begin
        @(posedge clk); #1;
        if (push_seen) src_idx++;
        if (src_idx < src_total) begin
            input_valid = feed_stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            input_data  = pat(src_idx);
        end else begin
            input_valid = 1'b0;
        end
    end

    task automatic start_job(input int len, input bit fst, input bit sst, input int eat, input bit feed);
        int rem;
        logic [47:0] a;
        rem = len;
        a = 48'h0000_4000_0000;
        while (rem > 0) begin
            int b;
            b = (rem > 16) ? 16 : rem;
            exp_aw_q.push_back({a, 8'(b - 1)});
            a   = a + 48'(b * 32);
            rem = rem - b;
        end
        err_at = eat;
        feed_stall = fst;
        slv_stall = sst;
        if (feed) src_total += len;
        @(posedge clk); #1;
        Write_Length = 32'(len);
        Write_Begin  = 1'b1;
        @(posedge clk); #1;
        Write_Begin  = 1'b0;
    endtask

    // n = falling edges after the Begin edge until Write_Done; aw1/err1 sampled at n = 1
    task automatic wait_done(output int n, output logic aw1, output logic err1);
        n = 0; aw1 = 1'b0; err1 = 1'b0;
        while (n < 3000) begin
            @(negedge clk);
            n++;
            if (n == 1) begin aw1 = awvalid; err1 = Write_Error; end
            if (Write_Done) break;
        end
        if (!Write_Done) begin
            n_checks++; n_errors++;
            $display("FAIL done_timeout: got no Write_Done expected a pulse within 3000 cycles");
        end
    endtask

    initial begin
        int n, d0;
        logic aw1, err1;

        // reset state
        #12;
        chk("rst_awvalid", awvalid, 1'b0);
        chk("rst_wvalid", wvalid, 1'b0);
        chk("rst_bready", bready, 1'b0);
        chk("rst_done_err", {Write_Done, Write_Error}, 2'b00);
        chk("rst_input_ready", input_ready, 1'b1);
        chk("rst_aw_fields", {awaddr, awlen}, 56'd0);
        chk("rst_wdata", wdata, 256'd0);
        chk("const_fields", {awsize, awburst, awcache, wstrb}, {3'b101, 2'b01, 4'b0011, 32'hFFFF_FFFF});
        @(negedge clk); rstn = 1'b1;

        // 1: length 4, four beats preloaded
        src_total += 4;
        n = 0;
        while (data_q.size() < 4 && n < 50) begin @(negedge clk); n++; end
        obs_aw_q.delete(); d0 = done_cnt;
        start_job(4, 0, 0, -1, 0);
        wait_done(n, aw1, err1);
        chk("t1_aw_latency", aw1, 1'b1);
        chk("t1_bursts", obs_aw_q.size(), 1);
        chk("t1_aw", obs_aw_q[0], {48'h0000_4000_0000, 8'd3});
        @(negedge clk);
        chk("t1_done_cnt", done_cnt, d0 + 1);

        // 2: length 37 with a Begin issued mid-job
        obs_aw_q.delete(); d0 = done_cnt;
        start_job(37, 0, 0, -1, 1);
        repeat (10) @(negedge clk);
        #1 Write_Length = 32'd5; Write_Begin = 1'b1;
        @(posedge clk); #1 Write_Begin = 1'b0;
        wait_done(n, aw1, err1);
        chk("t2_bursts", obs_aw_q.size(), 3);
        chk("t2_aw0", obs_aw_q[0], {48'h0000_4000_0000, 8'd15});
        chk("t2_aw1", obs_aw_q[1], {48'h0000_4000_0200, 8'd15});
        chk("t2_aw2", obs_aw_q[2], {48'h0000_4000_0400, 8'd4});
        chk("t2_b_per_aw", b_idx, 3);
        @(negedge clk);
        chk("t2_done_cnt", done_cnt, d0 + 1);

        // 3: random stalls, length 100, FIFO filled to 32 first
        feed_stall = 1;
        src_total += 100;
        n = 0;
        while (data_q.size() < 32 && n < 400) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        chk("t3_ready_full", input_ready, 1'b0);
        start_job(100, 1, 1, -1, 0);
        wait_done(n, aw1, err1);
        @(negedge clk);
        chk("t3_drained", data_q.size(), 0);
        slv_stall = 0; feed_stall = 0;

        // 4: length 0
        obs_aw_q.delete(); d0 = done_cnt;
        start_job(0, 0, 0, -1, 0);
        wait_done(n, aw1, err1);
        chk("t4_done_latency", n, 2);
        chk("t4_no_aw", aw1, 1'b0);
        @(negedge clk);
        chk("t4_aw_count", obs_aw_q.size(), 0);
        chk("t4_done_cnt", done_cnt, d0 + 1);

        // 5: SLVERR on the second burst, then cleared by the next Begin
        start_job(20, 0, 0, 1, 1);
        wait_done(n, aw1, err1);
        chk("t5_err_at_done", Write_Error, 1'b1);
        start_job(4, 0, 0, -1, 1);
        wait_done(n, aw1, err1);
        chk("t5_err_cleared", err1, 1'b0);
        chk("t5_err_end", Write_Error, 1'b0);

        // 6: reset while in DATA, then a normal job
        start_job(20, 0, 0, -1, 1);
        n = 0;
        while (!(in_burst && beats_left <= 18) && n < 200) begin @(negedge clk); n++; end
        #1 rstn = 1'b0;
        data_q.delete(); exp_aw_q.delete();
        in_burst = 0; job_active = 0; b_owed = 0; beats_left = 0; exp_err = 0;
        src_total = src_idx; push_seen = 0; input_valid = 1'b0;
        #1;
        chk("t6_wvalid", wvalid, 1'b0);
        chk("t6_input_ready", input_ready, 1'b1);
        chk("t6_awvalid_bready", {awvalid, bready}, 2'b00);
        chk("t6_wdata", wdata, 256'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t6_no_done", Write_Done, 1'b0);
        end
        #1 rstn = 1'b1;
        obs_aw_q.delete(); d0 = done_cnt;
        start_job(4, 0, 0, -1, 1);
        wait_done(n, aw1, err1);
        chk("t6_aw", obs_aw_q.size() > 0 ? obs_aw_q[0] : 56'd0, {48'h0000_4000_0000, 8'd3});
        @(negedge clk);
        chk("t6_done_cnt", done_cnt, d0 + 1);
        chk("t6_drained", data_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
